prsend: RTL and testbench

PRSEND -- requirements
Module: prsend

---
 rtl/prsend.sv | 129 ++++++++++++
 tb/tb_prsend.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prsend.sv
// prsend: frames a bitstream source into a PR stream and waits for the target.
// Each transaction sends a start marker, LEN payload words and an end marker.
// It then waits for the target's PR_DONE flag, or for a timeout.
module prsend #(
    parameter int          DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              START,
    input  logic [3:0]        ID,
    input  logic [15:0]       LEN,
    input  logic              S_VALID,
    input  logic [DWIDTH-1:0] S_DATA,
    output logic              S_READY,
    output logic              PR_VALID,
    output logic [DWIDTH-1:0] PR_DATA,
    input  logic [15:0]       PR_DONE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_BODY = 3'd2,
        ST_TAIL = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        id_q, id_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              pr_valid_q, pr_valid_d;
    logic [DWIDTH-1:0] pr_data_q, pr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              s_ready;

    // The source is only pulled in BODY while payload words remain.
    assign s_ready  = (state_q == ST_BODY) && (cnt_q != 16'd0);
    assign S_READY  = s_ready;
    assign BUSY     = (state_q != ST_IDLE);
    assign PR_VALID = pr_valid_q;
    assign PR_DATA  = pr_data_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

    // Next-state logic. The output word defaults to 0, so PR_DATA is 0 whenever PR_VALID is low.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        pr_valid_d = 1'b0;
        pr_data_d  = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    id_d    = ID;
                    cnt_d   = LEN;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                pr_valid_d = 1'b1;
                pr_data_d  = {4'hD, id_q, 8'h00, 16'hBEEF};
                state_d    = (cnt_q != 16'd0) ? ST_BODY : ST_TAIL;
            end
            ST_BODY: begin
                if (S_VALID && s_ready) begin
                    pr_valid_d = 1'b1;
                    pr_data_d  = S_DATA;
                    cnt_d      = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                pr_valid_d = 1'b1;
                pr_data_d  = {4'hD, id_q, 8'h00, 16'hDEAD};
                tmo_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 32'd1;
                // Success is checked first, so it wins over a timeout on the same cycle.
                if (PR_DONE[id_q]) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            pr_valid_q <= 1'b0;
            pr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            pr_valid_q <= pr_valid_d;
            pr_data_q  <= pr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_prsend.sv
// Directed bench for prsend: framing, stalls, zero length, timeout, mid-transaction reset.
module tb_prsend;

    logic        clk = 1'b0;
    logic        rstn;
    logic        START;
    logic [3:0]  ID;
    logic [15:0] LEN;
    logic        S_VALID;
    logic [31:0] S_DATA;
    logic        S_READY;
    logic        PR_VALID;
    logic [31:0] PR_DATA;
    logic [15:0] PR_DONE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    prsend #(.DWIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .START(START), .ID(ID), .LEN(LEN),
        .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY),
        .PR_VALID(PR_VALID), .PR_DATA(PR_DATA), .PR_DONE(PR_DONE),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // PR stream word: {valid, data}
    task automatic pr(input string tag, input logic v, input logic [31:0] d);
        chk(tag, {31'd0, PR_VALID, PR_DATA}, {31'd0, v, d});
    endtask

    // Status flags: {S_READY, BUSY, DONE, ERR}
    task automatic st(input string tag, input logic [3:0] exp);
        chk(tag, {60'd0, S_READY, BUSY, DONE, ERR}, {60'd0, exp});
    endtask

    initial begin
        rstn = 1'b0; START = 1'b0; ID = '0; LEN = '0;
        S_VALID = 1'b0; S_DATA = '0; PR_DONE = '0;
        #1;
        step(); step();
        pr("reset_pr", 1'b0, 32'h0);
        st("reset_st", 4'b0000);
        rstn = 1'b1;
        step();

        // ID=3, LEN=2, no stalls
        START = 1'b1; ID = 4'h3; LEN = 16'd2; S_VALID = 1'b1; S_DATA = 32'h11111111;
        step();
        START = 1'b0; ID = 4'h0; LEN = 16'd0;
        pr("t1_head_cycle", 1'b0, 32'h0);
        st("t1_head_st", 4'b0100);
        step();
        pr("t1_w0", 1'b1, 32'hD300BEEF);
        st("t1_body_st", 4'b1100);
        step();
        pr("t1_w1", 1'b1, 32'h11111111);
        S_DATA = 32'h22222222;
        step();
        pr("t1_w2", 1'b1, 32'h22222222);
        st("t1_tail_st", 4'b0100);
        S_VALID = 1'b0;
        step();
        pr("t1_w3", 1'b1, 32'hD300DEAD);
        step();
        pr("t1_after", 1'b0, 32'h0);
        st("t1_wait_st", 4'b0100);
        PR_DONE = 16'h0008;
        step();
        st("t1_done", 4'b0010);
        PR_DONE = 16'h0000;
        step();
        st("t1_idle", 4'b0000);

        // ID=A, LEN=0; other PR_DONE bits must be ignored
        START = 1'b1; ID = 4'hA; LEN = 16'd0;
        step();
        START = 1'b0;
        st("t2_head_st", 4'b0100);
        step();
        pr("t2_w0", 1'b1, 32'hDA00BEEF);
        st("t2_tail_st", 4'b0100);
        step();
        pr("t2_w1", 1'b1, 32'hDA00DEAD);
        st("t2_wait_st", 4'b0100);
        PR_DONE = 16'hFBFF;
        step();
        st("t2_other_bits0", 4'b0100);
        step();
        st("t2_other_bits1", 4'b0100);
        PR_DONE = 16'hFFFF;
        step();
        st("t2_done", 4'b0010);

        // back-to-back START in the DONE cycle: ID=5, LEN=3 with a 2-cycle stall
        START = 1'b1; ID = 4'h5; LEN = 16'd3; PR_DONE = 16'h0000;
        S_VALID = 1'b1; S_DATA = 32'hA1A1A1A1;
        step();
        START = 1'b0;
        st("t3_accepted", 4'b0100);
        step();
        pr("t3_w0", 1'b1, 32'hD500BEEF);
        step();
        pr("t3_w1", 1'b1, 32'hA1A1A1A1);
        S_VALID = 1'b0;
        step();
        pr("t3_gap0", 1'b0, 32'h0);
        step();
        pr("t3_gap1", 1'b0, 32'h0);
        S_VALID = 1'b1; S_DATA = 32'hA2A2A2A2;
        step();
        pr("t3_w2", 1'b1, 32'hA2A2A2A2);
        S_DATA = 32'hA3A3A3A3;
        step();
        pr("t3_w3", 1'b1, 32'hA3A3A3A3);
        S_VALID = 1'b0;
        step();
        pr("t3_w4", 1'b1, 32'hD500DEAD);
        PR_DONE = 16'h0020;
        step();
        pr("t3_no_extra", 1'b0, 32'h0);
        st("t3_done", 4'b0010);
        PR_DONE = 16'h0000;
        step();

        // timeout: ID=1, LEN=1, START during BODY ignored, PR_DONE held 0
        START = 1'b1; ID = 4'h1; LEN = 16'd1;
        step();
        START = 1'b0;
        step();
        pr("t4_w0", 1'b1, 32'hD100BEEF);
        START = 1'b1; ID = 4'h7; LEN = 16'd9;
        step();
        START = 1'b0;
        pr("t4_stall", 1'b0, 32'h0);
        st("t4_start_ignored", 4'b1100);
        S_VALID = 1'b1; S_DATA = 32'hC0FFEE00;
        step();
        pr("t4_w1", 1'b1, 32'hC0FFEE00);
        S_VALID = 1'b0;
        step();
        pr("t4_w2", 1'b1, 32'hD100DEAD);
        for (int i = 0; i < 7; i++) begin
            step();
            st($sformatf("t4_wait%0d", i + 2), 4'b0100);
        end
        step();
        st("t4_timeout", 4'b0011);
        step();
        st("t4_idle", 4'b0000);

        // reset mid-BODY, then ID=2, LEN=1
        START = 1'b1; ID = 4'h6; LEN = 16'd4; S_VALID = 1'b1; S_DATA = 32'h55555555;
        step();
        START = 1'b0;
        step();
        pr("t5_w0", 1'b1, 32'hD600BEEF);
        step();
        pr("t5_w1", 1'b1, 32'h55555555);
        rstn = 1'b0;
        step();
        pr("t5_rst_pr0", 1'b0, 32'h0);
        st("t5_rst_st0", 4'b0000);
        step();
        pr("t5_rst_pr1", 1'b0, 32'h0);
        st("t5_rst_st1", 4'b0000);
        rstn = 1'b1; S_VALID = 1'b0;
        step();
        pr("t5_no_tail0", 1'b0, 32'h0);
        st("t5_idle", 4'b0000);
        step();
        pr("t5_no_tail1", 1'b0, 32'h0);
        START = 1'b1; ID = 4'h2; LEN = 16'd1; S_VALID = 1'b1; S_DATA = 32'h77777777;
        step();
        START = 1'b0;
        pr("t5_head_cycle", 1'b0, 32'h0);
        step();
        pr("t5_w2", 1'b1, 32'hD200BEEF);
        step();
        pr("t5_w3", 1'b1, 32'h77777777);
        S_VALID = 1'b0;
        step();
        pr("t5_w4", 1'b1, 32'hD200DEAD);
        PR_DONE = 16'h0004;
        step();
        st("t5_done", 4'b0010);
        PR_DONE = 16'h0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
